// File: rtl/axis_m_pkg.sv
// Shared types for the AXI4-Stream master packet generator.
// Holds the FSM state encoding, the default-width command record and its width.
package axis_m_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 3;

  typedef enum logic {
    IDLE,
    TX
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] din;
    logic [DEF_LEN_W-1:0]  len;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/axis_m_cmd_fifo.sv
// Small synchronous command FIFO with first-word fall-through read data.
// rdata shows the head entry whenever empty is low; push when full and pop
// when empty are ignored. A push into an empty FIFO is not poppable until
// the following cycle.
module axis_m_cmd_fifo
  import axis_m_pkg::*;
#(
  parameter int WIDTH = CMD_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_m_pkt_gen.sv
// AXI4-Stream master packet generator.
// Commands {din, len} are queued in a small FIFO; each one becomes a packet of
// len+1 beats carrying din*beat, with TLAST on the final beat. All stream
// outputs decode registered state only, so nothing depends on m_axis_tready.
// Optional feature macro: AXIS_M_PKT_GEN_TUSER_EN adds m_axis_tuser (beat index).
module axis_m_pkt_gen
  import axis_m_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int CMD_DEPTH = 4
) (
  input  logic              m_axis_aclk,
  input  logic              m_axis_aresetn,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  input  logic [LEN_W-1:0]  len,
  output logic              cmd_ready,
  input  logic              m_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              pkt_done
`ifdef AXIS_M_PKT_GEN_TUSER_EN
  ,
  output logic [LEN_W-1:0]  m_axis_tuser
`endif
);

  localparam int CW = DATA_W + LEN_W;

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] cur_din;
  logic [DATA_W-1:0] cur_din_n;
  logic [LEN_W-1:0]  cur_len;
  logic [LEN_W-1:0]  cur_len_n;
  logic [LEN_W-1:0]  beat;
  logic [LEN_W-1:0]  beat_n;

  logic [CW-1:0]     cmd_rdata;
  logic [DATA_W-1:0] head_din;
  logic [LEN_W-1:0]  head_len;
  logic              cmd_full;
  logic              cmd_empty;
  logic              cmd_pop;
  logic              hs;
  logic              last_beat;
  logic [DATA_W-1:0] beat_ext;

  axis_m_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (m_axis_aclk),
    .rst_n (m_axis_aresetn),
    .push  (newd && cmd_ready),
    .wdata ({din, len}),
    .pop   (cmd_pop),
    .rdata (cmd_rdata),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  assign {head_din, head_len} = cmd_rdata;
  assign cmd_ready = !cmd_full;
  assign busy      = (state == TX) || !cmd_empty;
  assign hs        = m_axis_tvalid && m_axis_tready;
  assign last_beat = (beat == cur_len);

  // Resizing beat to DATA_W before multiplying keeps the product exact modulo 2**DATA_W.
  assign beat_ext      = DATA_W'(beat);
  assign m_axis_tvalid = (state == TX);
  assign m_axis_tdata  = m_axis_tvalid ? (cur_din * beat_ext) : '0;
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
`ifdef AXIS_M_PKT_GEN_TUSER_EN
  assign m_axis_tuser  = m_axis_tvalid ? beat : '0;
`endif

  // State, current command and beat registers; pkt_done marks the cycle after a TLAST handshake.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state    <= IDLE;
      cur_din  <= '0;
      cur_len  <= '0;
      beat     <= '0;
      pkt_done <= 1'b0;
    end else begin
      state    <= state_n;
      cur_din  <= cur_din_n;
      cur_len  <= cur_len_n;
      beat     <= beat_n;
      pkt_done <= hs && m_axis_tlast;
    end
  end

  // Next-state logic: load a command from the FIFO head, advance on handshakes,
  // and chain straight into the next queued command without an idle cycle.
  always_comb begin
    state_n   = state;
    cur_din_n = cur_din;
    cur_len_n = cur_len;
    beat_n    = beat;
    cmd_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!cmd_empty) begin
          cmd_pop   = 1'b1;
          state_n   = TX;
          cur_din_n = head_din;
          cur_len_n = head_len;
          beat_n    = '0;
        end
      end
      TX: begin
        if (hs) begin
          if (last_beat) begin
            beat_n = '0;
            if (!cmd_empty) begin
              cmd_pop   = 1'b1;
              cur_din_n = head_din;
              cur_len_n = head_len;
            end else begin
              state_n = IDLE;
            end
          end else begin
            beat_n = beat + LEN_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_m_pkt_gen.sv
// Self-checking bench for axis_m_pkt_gen.
// Accepted commands are expanded into expected beats by a plain arithmetic
// model and queued; an independent monitor pops and compares every handshake,
// and also watches pkt_done, AXIS stability and idle output values.
// Build with AXIS_M_PKT_GEN_TUSER_EN to also check m_axis_tuser.
module tb_axis_m_pkt_gen;

  localparam int DATA_W    = 8;
  localparam int LEN_W     = 3;
  localparam int CMD_DEPTH = 4;

  logic              m_axis_aclk    = 1'b0;
  logic              m_axis_aresetn = 1'b0;
  logic              newd           = 1'b0;
  logic [DATA_W-1:0] din            = '0;
  logic [LEN_W-1:0]  len            = '0;
  logic              m_axis_tready  = 1'b0;
  logic              cmd_ready;
  logic              m_axis_tvalid;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic              busy;
  logic              pkt_done;
`ifdef AXIS_M_PKT_GEN_TUSER_EN
  logic [LEN_W-1:0]  m_axis_tuser;
`endif

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [LEN_W-1:0]  user;
  } beat_t;

  beat_t exp_q[$];
  int    checks      = 0;
  int    errors      = 0;
  int    tready_mode = 0;
  int    pat_idx     = 0;
  bit    gap_watch   = 1'b0;
  int    gap_cnt     = 0;

  axis_m_pkt_gen #(
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .CMD_DEPTH (CMD_DEPTH)
  ) dut (
    .m_axis_aclk    (m_axis_aclk),
    .m_axis_aresetn (m_axis_aresetn),
    .newd           (newd),
    .din            (din),
    .len            (len),
    .cmd_ready      (cmd_ready),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .busy           (busy),
    .pkt_done       (pkt_done)
`ifdef AXIS_M_PKT_GEN_TUSER_EN
    ,
    .m_axis_tuser   (m_axis_tuser)
`endif
  );

  always #5 m_axis_aclk = ~m_axis_aclk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: a packet is beats 0..len of (din*beat) mod 2**DATA_W, last on beat len.
  function automatic void push_packet(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
    beat_t item;
    int    v;
    for (int b = 0; b <= int'(l); b++) begin
      v         = (int'(d) * b) % (1 << DATA_W);
      item.data = DATA_W'(v);
      item.last = (b == int'(l));
      item.user = LEN_W'(b);
      exp_q.push_back(item);
    end
  endfunction

  // Sink ready driver: 0 = held low, 1 = held high, 2 = random, 3 = pattern 1,0,0,1.
  always @(posedge m_axis_aclk) begin
    #1;
    case (tready_mode)
      0: m_axis_tready = 1'b0;
      1: m_axis_tready = 1'b1;
      2: m_axis_tready = 1'($urandom_range(0, 1));
      default: begin
        m_axis_tready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
        pat_idx++;
      end
    endcase
  end

  // Monitor: compare each handshake against the scoreboard and watch protocol rules.
  logic              exp_done   = 1'b0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  logic              prev_last  = 1'b0;
  beat_t             got;
  always @(negedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check_output("pkt_done", 32'(pkt_done), 32'(exp_done));
      exp_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
      if (prev_stall) begin
        check_output("tvalid_hold", 32'(m_axis_tvalid), 32'd1);
        check_output("tdata_hold", 32'(m_axis_tdata), 32'(prev_data));
        check_output("tlast_hold", 32'(m_axis_tlast), 32'(prev_last));
      end
      if (!m_axis_tvalid) begin
        check_output("idle_tdata_tlast", 32'({m_axis_tdata, m_axis_tlast}), 32'd0);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat actual=%0h required=none", m_axis_tdata);
        end else begin
          got = exp_q.pop_front();
          check_output("beat_data", 32'(m_axis_tdata), 32'(got.data));
          check_output("beat_last", 32'(m_axis_tlast), 32'(got.last));
`ifdef AXIS_M_PKT_GEN_TUSER_EN
          check_output("beat_user", 32'(m_axis_tuser), 32'(got.user));
`endif
        end
      end
      if (gap_watch && !m_axis_tvalid && exp_q.size() > 0) begin
        gap_cnt++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // Offer one command for up to max_tries cycles; queue its beats once accepted.
  task automatic apply_stimulus(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l,
                                input int max_tries, output bit accepted);
    bit ok;
    accepted = 1'b0;
    newd     = 1'b1;
    din      = d;
    len      = l;
    for (int t = 0; t < max_tries && !accepted; t++) begin
      @(negedge m_axis_aclk);
      ok = cmd_ready;
      @(posedge m_axis_aclk);
      if (ok) begin
        push_packet(d, l);
        accepted = 1'b1;
      end
      #1;
    end
    newd = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge m_axis_aclk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d beats left required=0", exp_q.size());
    end
    @(posedge m_axis_aclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  bit acc;
  int n_acc;
  initial begin
    // Reset values while aresetn is held low.
    #12;
    check_output("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_output("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check_output("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_pkt_done", 32'(pkt_done), 32'd0);
    check_output("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge m_axis_aclk);
    #1;
    m_axis_aresetn = 1'b1;
    @(posedge m_axis_aclk);
    #1;

    // Basic packet with the sink always ready.
    tready_mode = 1;
    apply_stimulus(8'h05, 3'd3, 4, acc);
    check_output("basic_accept", 32'(acc), 32'd1);
    wait_drain(100);

    // Longest packet under a 1,0,0,1 backpressure pattern.
    pat_idx     = 0;
    tready_mode = 3;
    apply_stimulus(8'h13, 3'd7, 4, acc);
    wait_drain(200);

    // Single-beat packet and truncation of the payload product.
    tready_mode = 1;
    apply_stimulus(8'hFF, 3'd0, 4, acc);
    wait_drain(100);
    apply_stimulus(8'h80, 3'd3, 4, acc);
    wait_drain(100);
`ifdef AXIS_M_PKT_GEN_TUSER_EN
    apply_stimulus(8'h21, 3'd2, 4, acc);
    wait_drain(100);
`endif

    // Stalled sink: one command enters TX, CMD_DEPTH more fill the FIFO, then it is full.
    tready_mode = 0;
    @(posedge m_axis_aclk);
    #1;
    n_acc = 0;
    for (int i = 0; i < CMD_DEPTH + 2; i++) begin
      apply_stimulus(8'($urandom), 3'($urandom), 1, acc);
      if (acc) n_acc++;
    end
    check_output("full_accept_count", 32'(n_acc), 32'(CMD_DEPTH + 1));
    check_output("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check_output("full_busy", 32'(busy), 32'd1);
    gap_cnt     = 0;
    gap_watch   = 1'b1;
    tready_mode = 1;
    wait_drain(500);
    gap_watch   = 1'b0;
    check_output("back_to_back_gaps", 32'(gap_cnt), 32'd0);
    check_output("drained_cmd_ready", 32'(cmd_ready), 32'd1);

    // Randomized commands against random backpressure.
    tready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(8'($urandom), 3'($urandom), 200, acc);
      check_output("rand_accept", 32'(acc), 32'd1);
      repeat ($urandom_range(0, 3)) @(posedge m_axis_aclk);
      #1;
    end
    wait_drain(3000);

    // Reset mid-packet with a second command still queued.
    tready_mode = 1;
    apply_stimulus(8'h11, 3'd7, 4, acc);
    apply_stimulus(8'h22, 3'd2, 4, acc);
    repeat (2) @(posedge m_axis_aclk);
    #3;
    m_axis_aresetn = 1'b0;
    #1;
    check_output("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_output("midrst_tlast", 32'(m_axis_tlast), 32'd0);
    check_output("midrst_tdata", 32'(m_axis_tdata), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    exp_q.delete();
    @(posedge m_axis_aclk);
    #3;
    m_axis_aresetn = 1'b1;
    @(posedge m_axis_aclk);
    #1;
    check_output("postrst_busy", 32'(busy), 32'd0);
    check_output("postrst_tvalid", 32'(m_axis_tvalid), 32'd0);

    // Recovery after reset.
    apply_stimulus(8'h03, 3'd2, 4, acc);
    wait_drain(100);

    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
